// File: rtl/wait_mem.sv
// Dual-port word memory with request/ready handshake, fixed access latency,
// byte-enabled writes on port 1 and an optional zeroing sweep after reset.
module wait_mem #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned LATENCY        = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  init_done,
  input  logic                  p1_read,
  input  logic                  p1_write,
  input  logic [ADDR_W-1:0]     p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [DATA_W/8-1:0]   p1_be,
  output logic                  p1_ready,
  output logic                  p1_done,
  output logic [DATA_W-1:0]     p1_rdata,
  input  logic                  p2_read,
  input  logic [ADDR_W-1:0]     p2_addr,
  output logic                  p2_ready,
  output logic                  p2_done,
  output logic [DATA_W-1:0]     p2_rdata
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [2:0]        CntLoad  = 3'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  localparam logic GsInit = 1'b0;
  localparam logic GsRun  = 1'b1;
  localparam logic PsIdle = 1'b0;
  localparam logic PsWait = 1'b1;

  logic [DATA_W-1:0] mem [Depth];

  // Global init sequencing
  logic              gState;
  logic [ADDR_W-1:0] initPtr;
  logic              sweepWe;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gState  <= GsInit;
      initPtr <= '0;
    end else if (gState == GsInit) begin
      if (!CLEAR_ON_RESET || initPtr == LastAddr) begin
        gState <= GsRun;
      end
      initPtr <= initPtr + 1'b1;
    end
  end

  assign init_done = (gState == GsRun);
  // Gate on reset so a held reset never sweeps address 0 repeatedly.
  assign sweepWe   = reset && (gState == GsInit) && CLEAR_ON_RESET;

  // Port 1: read/write
  logic              p1State;
  logic [2:0]        p1Cnt;
  logic              p1IsWrite;
  logic [ADDR_W-1:0] p1AddrQ;
  logic [DATA_W-1:0] p1WdataQ;
  logic [BeW-1:0]    p1BeQ;
  logic              p1Accept;
  logic              p1Access;

  assign p1_ready = init_done && (p1State == PsIdle);
  assign p1Accept = p1_ready && (p1_read || p1_write);
  assign p1Access = (p1State == PsWait) && (p1Cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p1State   <= PsIdle;
      p1Cnt     <= '0;
      p1IsWrite <= 1'b0;
      p1AddrQ   <= '0;
      p1WdataQ  <= '0;
      p1BeQ     <= '0;
      p1_done   <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p1_done <= 1'b0;
      if (p1Accept) begin
        p1State   <= PsWait;
        p1Cnt     <= CntLoad;
        p1IsWrite <= p1_write;
        p1AddrQ   <= p1_addr;
        p1WdataQ  <= p1_wdata;
        p1BeQ     <= p1_be;
      end else if (p1State == PsWait) begin
        if (p1Access) begin
          p1State <= PsIdle;
          p1_done <= 1'b1;
          if (!p1IsWrite) begin
            p1_rdata <= mem[p1AddrQ];
          end
        end else begin
          p1Cnt <= p1Cnt - 1'b1;
        end
      end
    end
  end

  // Port 2: read-only
  logic              p2State;
  logic [2:0]        p2Cnt;
  logic [ADDR_W-1:0] p2AddrQ;
  logic              p2Accept;

  assign p2_ready = init_done && (p2State == PsIdle);
  assign p2Accept = p2_ready && p2_read;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p2State  <= PsIdle;
      p2Cnt    <= '0;
      p2AddrQ  <= '0;
      p2_done  <= 1'b0;
      p2_rdata <= '0;
    end else begin
      p2_done <= 1'b0;
      if (p2Accept) begin
        p2State <= PsWait;
        p2Cnt   <= CntLoad;
        p2AddrQ <= p2_addr;
      end else if (p2State == PsWait) begin
        if (p2Cnt == '0) begin
          p2State  <= PsIdle;
          p2_done  <= 1'b1;
          // Same-edge p1 write is not yet visible here: read-before-write.
          p2_rdata <= mem[p2AddrQ];
        end else begin
          p2Cnt <= p2Cnt - 1'b1;
        end
      end
    end
  end

  // Array storage; never reset so CLEAR_ON_RESET=0 preserves contents.
  always_ff @(posedge clock) begin
    if (sweepWe) begin
      mem[initPtr] <= '0;
    end else if (p1Access && p1IsWrite) begin
      for (int i = 0; i < BeW; i++) begin
        if (p1BeQ[i]) begin
          mem[p1AddrQ][8*i +: 8] <= p1WdataQ[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wait_mem.sv
// Scoreboard bench for wait_mem: a reference memory predicts every completion,
// a negedge monitor checks timing and data of each done pulse.
module tb_wait_mem;

  localparam int unsigned LatA = 3;
  localparam int unsigned LatB = 4;

  typedef struct {
    int          doneEdge;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic rstA  = 1'b1;
  logic rstB  = 1'b1;
  int   edgeCnt = 0;

  always #5 clock = ~clock;
  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  // DUT A: LATENCY=3, cleared on reset
  logic        aInitDone, p1Read, p1Write, p1Ready, p1Done, p2Read, p2Ready, p2Done;
  logic [3:0]  p1Addr, p2Addr, p1Be;
  logic [31:0] p1Wdata, p1Rdata, p2Rdata;

  // DUT B: LATENCY=4, contents kept across reset
  logic        bInitDone, bP1Read, bP1Write, bP1Ready, bP1Done, bP2Read, bP2Ready, bP2Done;
  logic [3:0]  bP1Addr, bP2Addr, bP1Be;
  logic [31:0] bP1Wdata, bP1Rdata, bP2Rdata;

  wait_mem #(.DATA_W(32), .ADDR_W(4), .LATENCY(LatA), .CLEAR_ON_RESET(1'b1)) dutA (
    .clock(clock), .reset(rstA), .init_done(aInitDone),
    .p1_read(p1Read), .p1_write(p1Write), .p1_addr(p1Addr), .p1_wdata(p1Wdata),
    .p1_be(p1Be), .p1_ready(p1Ready), .p1_done(p1Done), .p1_rdata(p1Rdata),
    .p2_read(p2Read), .p2_addr(p2Addr), .p2_ready(p2Ready), .p2_done(p2Done),
    .p2_rdata(p2Rdata)
  );

  wait_mem #(.DATA_W(32), .ADDR_W(4), .LATENCY(LatB), .CLEAR_ON_RESET(1'b0)) dutB (
    .clock(clock), .reset(rstB), .init_done(bInitDone),
    .p1_read(bP1Read), .p1_write(bP1Write), .p1_addr(bP1Addr), .p1_wdata(bP1Wdata),
    .p1_be(bP1Be), .p1_ready(bP1Ready), .p1_done(bP1Done), .p1_rdata(bP1Rdata),
    .p2_read(bP2Read), .p2_addr(bP2Addr), .p2_ready(bP2Ready), .p2_done(bP2Done),
    .p2_rdata(bP2Rdata)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] refMem [16];
  bit          modelInit = 1'b0;
  int          free1 = 0, free2 = 0;
  logic [31:0] lastRd1 = '0, lastRd2 = '0;
  exp_t        q1[$], q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edgeCnt, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Monitor: every done pulse must match the oldest prediction for its port.
  always @(negedge clock) begin
    exp_t e;
    if (p1Done) begin
      if (q1.size() == 0) check("p1_done unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("p1_done edge", edgeCnt, e.doneEdge);
        check("p1_rdata", p1Rdata, e.data);
      end
    end else if (q1.size() != 0 && q1[0].doneEdge <= edgeCnt) begin
      e = q1.pop_front();
      check("p1_done missing", 32'd0, 32'd1);
    end
    if (p2Done) begin
      if (q2.size() == 0) check("p2_done unexpected", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        check("p2_done edge", edgeCnt, e.doneEdge);
        check("p2_rdata", p2Rdata, e.data);
      end
    end else if (q2.size() != 0 && q2[0].doneEdge <= edgeCnt) begin
      e = q2.pop_front();
      check("p2_done missing", 32'd0, 32'd1);
    end
  end

  // Apply one cycle of requests at a negedge; acceptance is decided by the model.
  task automatic drive(input bit r1, input bit w1, input logic [3:0] a1, input logic [31:0] d1,
                       input logic [3:0] be1, input bit r2, input logic [3:0] a2);
    bit rdy1, rdy2;
    rdy1 = modelInit && (edgeCnt + 1 >= free1);
    rdy2 = modelInit && (edgeCnt + 1 >= free2);
    check("p1_ready", p1Ready, rdy1);
    check("p2_ready", p2Ready, rdy2);
    p1Read = r1; p1Write = w1; p1Addr = a1; p1Wdata = d1; p1Be = be1;
    p2Read = r2; p2Addr = a2;
    if (rdy2 && r2) begin
      lastRd2 = refMem[a2];
      q2.push_back('{doneEdge: edgeCnt + 1 + LatA, data: lastRd2});
      free2 = edgeCnt + 2 + LatA;
    end
    if (rdy1 && (r1 || w1)) begin
      if (w1) begin
        for (int i = 0; i < 4; i++) if (be1[i]) refMem[a1][8*i +: 8] = d1[8*i +: 8];
      end else begin
        lastRd1 = refMem[a1];
      end
      q1.push_back('{doneEdge: edgeCnt + 1 + LatA, data: lastRd1});
      free1 = edgeCnt + 2 + LatA;
    end
    tick();
    p1Read = 1'b0; p1Write = 1'b0; p2Read = 1'b0;
  endtask

  task automatic waitFree();
    int n = 0;
    while ((edgeCnt + 1 < free1 || edgeCnt + 1 < free2) && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check("drain within bound", 32'(n < 50), 32'd1);
    repeat (LatA + 2) tick();
  endtask

  task automatic resetA(input bit poke);
    int n, rel;
    tick();
    #1 rstA = 1'b0;
    #1;
    check("A rst init_done", aInitDone, 0);
    check("A rst p1_ready", p1Ready, 0);
    check("A rst p2_ready", p2Ready, 0);
    check("A rst p1_done", p1Done, 0);
    check("A rst p2_done", p2Done, 0);
    check("A rst p1_rdata", p1Rdata, 0);
    check("A rst p2_rdata", p2Rdata, 0);
    q1.delete(); q2.delete();
    modelInit = 1'b0; free1 = 0; free2 = 0; lastRd1 = '0; lastRd2 = '0;
    foreach (refMem[i]) refMem[i] = '0;
    repeat (2) tick();
    rstA = 1'b1;
    rel  = edgeCnt;
    if (poke) begin
      p1Read = 1'b1; p1Addr = 4'd2; p2Read = 1'b1; p2Addr = 4'd3;
      tick();
      check("A p1_ready in init", p1Ready, 0);
      check("A p2_ready in init", p2Ready, 0);
      p1Read = 1'b0; p2Read = 1'b0;
    end
    n = 0;
    while (!aInitDone && n < 100) begin
      tick();
      n++;
    end
    check("A init_done edges", edgeCnt - rel, 16);
    modelInit = 1'b1;
  endtask

  task automatic resetB();
    int n, rel;
    tick();
    #1 rstB = 1'b0;
    #1;
    check("B rst init_done", bInitDone, 0);
    check("B rst p1_ready", bP1Ready, 0);
    check("B rst p2_ready", bP2Ready, 0);
    check("B rst p1_done", bP1Done, 0);
    check("B rst p1_rdata", bP1Rdata, 0);
    check("B rst p2_rdata", bP2Rdata, 0);
    repeat (2) tick();
    rstB = 1'b1;
    rel  = edgeCnt;
    n = 0;
    while (!bInitDone && n < 20) begin
      tick();
      n++;
    end
    check("B init_done edges", edgeCnt - rel, 1);
  endtask

  task automatic bStart(input bit wr, input logic [3:0] a, input logic [31:0] d, output int acc);
    check("B p1_ready idle", bP1Ready, 1);
    bP1Read = !wr; bP1Write = wr; bP1Addr = a; bP1Wdata = d; bP1Be = 4'hf;
    acc = edgeCnt + 1;
    tick();
    check("B p1_ready busy", bP1Ready, 0);
    bP1Read = 1'b0; bP1Write = 1'b0;
  endtask

  task automatic bFinish(input int acc, input logic [31:0] expData);
    int n = 0;
    while (!bP1Done && n < 20) begin
      tick();
      n++;
    end
    check("B p1_done latency", edgeCnt - acc, LatB);
    check("B p1_rdata", bP1Rdata, expData);
  endtask

  initial begin
    int acc;
    bit r1, w1, r2;
    logic [3:0]  a1, a2, be;
    logic [31:0] d;
    p1Read = 0; p1Write = 0; p1Addr = 0; p1Wdata = 0; p1Be = 0; p2Read = 0; p2Addr = 0;
    bP1Read = 0; bP1Write = 0; bP1Addr = 0; bP1Wdata = 0; bP1Be = 0; bP2Read = 0; bP2Addr = 0;
    #2 rstB = 1'b0;

    resetB();
    resetA(1'b1);

    for (int i = 0; i < 16; i++) begin
      waitFree();
      drive(0, 0, 4'd0, 32'd0, 4'h0, 1, 4'(i));
    end
    waitFree(); drive(0, 1, 4'd5, 32'hDEADBEEF, 4'hf, 0, 4'd0);
    waitFree(); drive(1, 0, 4'd5, 32'd0, 4'h0, 0, 4'd0);
    waitFree(); drive(0, 1, 4'd5, 32'h11223344, 4'b0101, 0, 4'd0);
    waitFree(); drive(1, 0, 4'd5, 32'd0, 4'h0, 0, 4'd0);
    waitFree(); drive(0, 1, 4'd7, 32'hAAAAAAAA, 4'hf, 0, 4'd0);
    waitFree(); drive(0, 1, 4'd7, 32'h55555555, 4'hf, 1, 4'd7);
    waitFree(); drive(0, 0, 4'd0, 32'd0, 4'h0, 1, 4'd7);
    // Requests while busy must be dropped.
    waitFree(); drive(1, 0, 4'd5, 32'd0, 4'h0, 0, 4'd0);
    drive(1, 0, 4'd2, 32'd0, 4'h0, 0, 4'd0);
    drive(0, 1, 4'd5, 32'hFFFFFFFF, 4'hf, 0, 4'd0);
    waitFree(); drive(0, 1, 4'd5, 32'hFFFFFFFF, 4'h0, 0, 4'd0);
    waitFree(); drive(1, 1, 4'd5, 32'h0BADF00D, 4'b1000, 0, 4'd0);
    waitFree(); drive(1, 0, 4'd5, 32'd0, 4'h0, 1, 4'd5);
    drain();

    repeat (400) begin
      r1 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      a1 = 4'($urandom_range(0, 7));
      a2 = 4'($urandom_range(0, 7));
      be = 4'($urandom_range(0, 15));
      d  = $urandom;
      drive(r1, w1, a1, d, be, r2, a2);
    end
    drain();

    // Abort an in-flight write with reset; sweep must rerun.
    waitFree(); drive(0, 1, 4'd9, 32'h13579BDF, 4'hf, 0, 4'd0);
    resetA(1'b0);
    waitFree(); drive(1, 0, 4'd9, 32'd0, 4'h0, 1, 4'd5);
    drain();

    bStart(1'b1, 4'd3, 32'hCAFEF00D, acc);
    bFinish(acc, 32'd0);
    bStart(1'b0, 4'd3, 32'd0, acc);
    bFinish(acc, 32'hCAFEF00D);
    bStart(1'b1, 4'd3, 32'h12345678, acc);
    tick();
    resetB();
    bStart(1'b0, 4'd3, 32'd0, acc);
    bFinish(acc, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wait_mem.md
# wait_mem

Parametrised dual-port word memory with per-port request/ready handshake, programmable access latency, byte-enabled writes and a post-reset clearing sweep. Successor to the fixed single-cycle data/instruction memory beside `cpu`. Port 1 is the CPU data port (read/write); port 2 is the instruction-fetch port (read-only). Lets the CPU be exercised against slow memory, with deterministic contents after reset.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- ADDR_W, 10, word address width; depth = 2^ADDR_W words
- LATENCY, 1, cycles from request acceptance to access; legal 1..7
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents untouched

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- init_done  out  1  high once the clearing sweep has finished
- p1_read  in  1  port 1 read request
- p1_write  in  1  port 1 write request
- p1_addr  in  ADDR_W  port 1 word address
- p1_wdata  in  DATA_W  port 1 write data
- p1_be  in  DATA_W/8  port 1 byte enables; bit i covers bits 8i+7..8i
- p1_ready  out  1  port 1 can accept a request
- p1_done  out  1  one-cycle pulse: port 1 access complete
- p1_rdata  out  DATA_W  port 1 read data, valid while p1_done follows a read
- p2_read  in  1  port 2 read request
- p2_addr  in  ADDR_W  port 2 word address
- p2_ready  out  1  port 2 can accept a request
- p2_done  out  1  one-cycle pulse: port 2 read complete
- p2_rdata  out  DATA_W  port 2 read data, valid while p2_done is high

## Operation
- Global FSM: RESET -> INIT -> RUN. In INIT (CLEAR_ON_RESET=1), an internal pointer writes zero to address 0, 1, ... 2^ADDR_W-1, one word per clock. With CLEAR_ON_RESET=0, INIT lasts one cycle.
- Both ports are held in IDLE with ready low until init_done is high.
- Per-port FSM: IDLE -> WAIT -> IDLE.
  - IDLE: ready=1. A request sampled high at an edge is accepted. Address, wdata, be and op are latched; counter is loaded with LATENCY-1; next state WAIT; ready=0.
  - WAIT: the counter decrements each edge. At the edge where the counter is 0, the access is performed. Reads register the word into rdata. Writes update only the bytes whose be bit is 1. done=1 for the following cycle; next state IDLE.
- Request inputs are ignored while ready=0; no queueing.
- p1_read and p1_write both high: treated as a write; no read data is returned.
- A write with p1_be=0 completes normally (done pulses) and changes nothing.
- rdata holds its last value between accesses. After a write, p1_rdata is unchanged.
- Port collision: a p1 write and a p2 read to the same address on the same edge -> p2 returns the old word (read-before-write). The new word is visible to later reads.
- Ports are fully independent; there is no arbitration stall.

## Timing
- Reset (reset low) immediately forces all outputs to 0: init_done, p*_ready, p*_done, p*_rdata. Both port FSMs go to IDLE, the INIT pointer goes to 0, and in-flight accesses are aborted. An aborted write does not modify the array.
- After reset deasserts (first edge with reset high = edge 0):
  - CLEAR_ON_RESET=1: the sweep writes addresses at edges 0..2^ADDR_W-1. init_done and ready rise after edge 2^ADDR_W-1.
  - CLEAR_ON_RESET=0: init_done rises after edge 0.
- Request accepted at edge k -> access at edge k+LATENCY -> done high between edges k+LATENCY and k+LATENCY+1.
- ready returns high in the same cycle as done. The earliest next acceptance is edge k+LATENCY+1, giving throughput of 1 access per LATENCY+1 cycles.
- Reset asserted during the INIT sweep restarts the sweep from address 0.

## Test plan
- ADDR_W=4, CLEAR_ON_RESET=1, LATENCY=1; reset low 2 cycles, then release -> init_done rises exactly 16 edges after release. p2 reads of addresses 0..15 all return 0x00000000.
- LATENCY=3: p1 writes 0xDEADBEEF to address 5 with be=4'b1111, then p1 reads address 5 -> each p1_done comes exactly 3 edges after its acceptance. p1_ready stays low for 3 cycles. The read returns 0xDEADBEEF.
- Byte enables: address 5 holds 0xDEADBEEF; write 0x11223344 with be=4'b0101 -> a later read returns 0xDE22BE44.
- Collision: address 7 holds 0xAAAAAAAA. p1 writes 0x55555555 and p2 reads address 7, both accepted on the same edge with equal LATENCY -> p2_rdata = 0xAAAAAAAA. A subsequent p2 read returns 0x55555555.
- Reset mid-access: LATENCY=4, p1 write accepted, reset pulsed low 2 cycles later -> all outputs are 0 during reset. Address is unchanged when CLEAR_ON_RESET=0; with CLEAR_ON_RESET=1 the sweep reruns and the address reads 0.
- Requests during INIT or while ready=0: pulse p1_read for one cycle before init_done, then pulse it again mid-WAIT -> neither produces a p1_done; only explicitly accepted requests complete.
